// File: rtl/hp_round_ctrl.sv
// hp_round_ctrl: HUD round/HP sequencer; optional low-HP blink with HP_BLINK_EN
module hp_round_ctrl #(
   parameter int TOTAL_HP = 20,
   parameter int PEND_MAX = 31,
   parameter int KO_FRAMES = 120
`ifdef HP_BLINK_EN
   ,
   parameter int LOW_HP = 5,
   parameter int BLINK_FRAMES = 8
`endif
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        round_start,
   input  logic        hit1_valid,
   input  logic [4:0]  hit1_dmg,
   input  logic        hit2_valid,
   input  logic [4:0]  hit2_dmg,
   output logic [18:0] hp1,
   output logic [18:0] hp2,
   output logic        exist_hp,
   output logic        ko1,
   output logic        ko2,
   output logic        round_over,
   output logic        blink1,
   output logic        blink2
);
   typedef enum logic [1:0] {IDLE, FIGHT, KO, DONE} state_t;
   localparam logic [4:0] HP_FULL = 5'(TOTAL_HP);
   localparam logic [4:0] PMAX = 5'(PEND_MAX);
   localparam logic [6:0] KO_LAST = 7'(KO_FRAMES - 1);
   state_t state_q, state_n;
   logic [1:0][4:0] hp_q, hp_n, pend_q, pend_n, hit_d;
   logic [1:0][5:0] sum;
   logic [1:0] ko_q, ko_n, hit_v, drn;
   logic [6:0] cnt_q, cnt_n;
   logic exist_q, exist_n, over_q, over_n;
   logic fr_q, fr_p, tick_q;
   assign hit_v = {hit2_valid, hit1_valid};
   assign hit_d = {hit2_dmg, hit1_dmg};
   assign hp1 = {14'd0, hp_q[0]};
   assign hp2 = {14'd0, hp_q[1]};
   assign exist_hp = exist_q;
   assign ko1 = ko_q[0];
   assign ko2 = ko_q[1];
   assign round_over = over_q;
   // frame pulse edge detect: one-cycle tick on each rising edge of frame_clk
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fr_q <= 1'b0;
         fr_p <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         fr_q <= frame_clk;
         fr_p <= fr_q;
         tick_q <= fr_q & ~fr_p;
      end
   end
   // round state, HP and pending-damage registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         hp_q <= {HP_FULL, HP_FULL};
         pend_q <= '0;
         ko_q <= '0;
         exist_q <= 1'b0;
         cnt_q <= '0;
         over_q <= 1'b0;
      end else begin
         state_q <= state_n;
         hp_q <= hp_n;
         pend_q <= pend_n;
         ko_q <= ko_n;
         exist_q <= exist_n;
         cnt_q <= cnt_n;
         over_q <= over_n;
      end
   end
   // next state: restart, hit accumulation with per-frame drain, KO hold timing
   always_comb begin
      state_n = state_q;
      hp_n = hp_q;
      pend_n = pend_q;
      ko_n = ko_q;
      exist_n = exist_q;
      cnt_n = cnt_q;
      over_n = 1'b0;
      sum = '0;
      drn = '0;
      if (round_start) begin
         state_n = FIGHT;
         hp_n = {HP_FULL, HP_FULL};
         pend_n = '0;
         ko_n = '0;
         exist_n = 1'b1;
         cnt_n = '0;
      end else if (state_q == FIGHT) begin
         for (int i = 0; i < 2; i++) begin
            drn[i] = tick_q && pend_q[i] != '0 && hp_q[i] != '0;
            sum[i] = {1'b0, pend_q[i]} + (hit_v[i] ? {1'b0, hit_d[i]} : 6'd0) - {5'd0, drn[i]};
            hp_n[i] = hp_q[i] - {4'd0, drn[i]};
            pend_n[i] = hp_n[i] == '0 ? 5'd0 : sum[i] > {1'b0, PMAX} ? PMAX : sum[i][4:0];
         end
         if (hp_n[0] == '0 || hp_n[1] == '0) begin
            state_n = KO;
            ko_n = {hp_n[1] == '0, hp_n[0] == '0};
            cnt_n = '0;
         end
      end else if (state_q == KO && tick_q) begin
         cnt_n = cnt_q + 7'd1;
         if (cnt_q == KO_LAST) begin
            state_n = DONE;
            over_n = 1'b1;
         end
      end
   end
`ifdef HP_BLINK_EN
   logic [1:0] blk_q, on_q, elig;
   logic [1:0][7:0] bc_q;
   assign elig[0] = (state_q == FIGHT || state_q == KO) && hp_q[0] != '0 && hp_q[0] <= 5'(LOW_HP);
   assign elig[1] = (state_q == FIGHT || state_q == KO) && hp_q[1] != '0 && hp_q[1] <= 5'(LOW_HP);
   assign blink1 = blk_q[0];
   assign blink2 = blk_q[1];
   // low-HP blink: first eligible tick turns on, then toggles every BLINK_FRAMES ticks
   always_ff @(posedge Clk) begin
      if (Reset) begin
         blk_q <= '0;
         on_q <= '0;
         bc_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!elig[i]) begin
               blk_q[i] <= 1'b0;
               on_q[i] <= 1'b0;
               bc_q[i] <= '0;
            end else if (tick_q && !on_q[i]) begin
               blk_q[i] <= 1'b1;
               on_q[i] <= 1'b1;
               bc_q[i] <= '0;
            end else if (tick_q && bc_q[i] == 8'(BLINK_FRAMES - 1)) begin
               blk_q[i] <= ~blk_q[i];
               bc_q[i] <= '0;
            end else if (tick_q) begin
               bc_q[i] <= bc_q[i] + 8'd1;
            end
         end
      end
   end
`else
   assign blink1 = 1'b0;
   assign blink2 = 1'b0;
`endif
endmodule

// File: tb/tb_hp_round_ctrl.sv
// tb_hp_round_ctrl: directed self-checking bench for hp_round_ctrl
module tb_hp_round_ctrl;
   logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, round_start = 1'b0;
   logic hit1_valid = 1'b0, hit2_valid = 1'b0;
   logic [4:0] hit1_dmg = '0, hit2_dmg = '0;
   logic [18:0] hp1, hp2;
   logic exist_hp, ko1, ko2, round_over, blink1, blink2;
   int n_chk = 0, n_fail = 0, ro_cnt = 0, ro_save;
`ifdef HP_BLINK_EN
   localparam logic BL = 1'b1;
`else
   localparam logic BL = 1'b0;
`endif
   hp_round_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .round_start(round_start),
      .hit1_valid(hit1_valid), .hit1_dmg(hit1_dmg), .hit2_valid(hit2_valid), .hit2_dmg(hit2_dmg),
      .hp1(hp1), .hp2(hp2), .exist_hp(exist_hp), .ko1(ko1), .ko2(ko2),
      .round_over(round_over), .blink1(blink1), .blink2(blink2)
   );
   always #5 Clk = ~Clk;
   // count round_over pulses, sampled away from the active edge
   always @(negedge Clk) if (round_over) ro_cnt++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_clk = 1'b1;
         @(negedge Clk);
         frame_clk = 1'b0;
         repeat (4) @(negedge Clk);
      end
   endtask
   task automatic drive(input logic rs, input logic v1, input logic [4:0] d1, input logic v2, input logic [4:0] d2);
      round_start = rs;
      hit1_valid = v1;
      hit1_dmg = d1;
      hit2_valid = v2;
      hit2_dmg = d2;
      @(negedge Clk);
      round_start = 1'b0;
      hit1_valid = 1'b0;
      hit2_valid = 1'b0;
   endtask
   initial begin
      repeat (3) @(negedge Clk);
      chk("rst_hp1", hp1, 20);
      chk("rst_hp2", hp2, 20);
      chk("rst_exist", exist_hp, 0);
      chk("rst_ko", {ko2, ko1}, 0);
      chk("rst_over", round_over, 0);
      Reset = 1'b0;
      @(negedge Clk);
      drive(1, 0, 0, 0, 0);
      chk("start_exist", exist_hp, 1);
      chk("start_hp", {hp2[7:0], hp1[7:0]}, {8'd20, 8'd20});
      chk("start_ko", {ko2, ko1}, 0);
      drive(0, 1, 3, 0, 0);
      frames(1);
      chk("drain_t1", hp1, 19);
      frames(1);
      chk("drain_t2", hp1, 18);
      frames(1);
      chk("drain_t3", hp1, 17);
      frames(2);
      chk("drain_t5", hp1, 17);
      chk("drain_hp2", hp2, 20);
      drive(0, 0, 0, 1, 25);
      drive(0, 0, 0, 1, 10);
      frames(19);
      chk("sat_hp2_19", hp2, 1);
      chk("sat_ko2_19", ko2, 0);
      chk("blink2_off", blink2, 0);
      frames(1);
      chk("ko_hp2", hp2, 0);
      chk("ko_flags", {ko2, ko1}, 2'b10);
      chk("ko_hp1", hp1, 17);
      frames(119);
      chk("ko_hold_119", ro_cnt, 0);
      frames(1);
      chk("round_over_pulse", ro_cnt, 1);
      repeat (5) @(negedge Clk);
      chk("round_over_single", ro_cnt, 1);
      drive(0, 1, 5, 0, 0);
      frames(2);
      chk("done_hit_ignored", hp1, 17);
      chk("done_exist", exist_hp, 1);
      chk("done_ko", {ko2, ko1}, 2'b10);
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 19, 1, 19);
      frames(19);
      chk("draw_pre_hp", {hp2[7:0], hp1[7:0]}, {8'd1, 8'd1});
      chk("draw_pre_ko", {ko2, ko1}, 0);
      drive(0, 1, 1, 1, 1);
      frames(1);
      chk("draw_hp", {hp2[7:0], hp1[7:0]}, 0);
      chk("draw_ko", {ko2, ko1}, 2'b11);
      drive(1, 1, 5, 0, 0);
      chk("restart_ko", {ko2, ko1}, 0);
      frames(2);
      chk("start_beats_hit", hp1, 20);
      drive(0, 1, 14, 0, 0);
      frames(10);
      chk("mid_hp1", hp1, 10);
      ro_save = ro_cnt;
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("mid_rst_hp1", hp1, 20);
      chk("mid_rst_exist", exist_hp, 0);
      @(negedge Clk);
      chk("mid_rst_no_over", ro_cnt, ro_save);
      drive(1, 0, 0, 0, 0);
      frames(2);
      chk("mid_rst_pend", hp1, 20);
      drive(0, 1, 15, 0, 0);
      frames(15);
      chk("low_hp1", hp1, 5);
      chk("blink_pre", blink1, 0);
      frames(1);
      chk("blink_t1", blink1, BL);
      frames(7);
      chk("blink_t8", blink1, BL);
      frames(1);
      chk("blink_t9", blink1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
